// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and sizing helpers for the unified-memory port arbiter.
//   arb_state_e  : arbiter FSM states (IDLE, BUSY, DONE)
//   arb_owner_e  : which pipeline port owns the current memory transaction
//   WD_CNT_W     : watchdog counter width for the default timeout
//   wd_cnt_width : watchdog counter width for any timeout value
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } arb_owner_e;

    localparam int TIMEOUT_DEFAULT = 64;
    localparam int WD_CNT_W        = $clog2(TIMEOUT_DEFAULT + 1);

    function automatic int wd_cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/arb_watchdog.sv
// ---------------------------------------------------------------------------
// arb_watchdog
// Counts cycles spent waiting on the memory and flags the cycle in which the
// wait reaches TIMEOUT cycles. The first counted cycle is count 1.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : return the count to zero (arbiter not waiting)
//   count_en   : arbiter is waiting this cycle
//   expired    : this is the TIMEOUT-th waiting cycle
// ---------------------------------------------------------------------------
module arb_watchdog
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int CNT_W   = WD_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // cnt_q holds the number of waiting cycles already completed, so the
    // cycle being counted right now is cnt_q + 1.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (count_en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = count_en & (cnt_q == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported memory between the fetch (if_*) and load/store
// (dm_*) ports. One transaction at a time: IDLE arbitrates, BUSY holds the
// memory request until mem_ack or watchdog timeout, DONE pulses the owner's
// valid for one cycle. Data wins ties (older instruction).
// Optional feature (macro ARB_STARVE_GUARD_EN): after MAX_STREAK consecutive
// data grants with fetch waiting, the next tie goes to fetch.
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   if_req/if_addr                  : fetch request, held until if_valid
//   if_rdata/if_valid               : fetch completion
//   dm_req/dm_we/dm_addr/dm_wdata   : data request, held until dm_valid
//   dm_rdata/dm_valid               : data completion
//   mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ack : memory side
//   err                             : timeout, qualifies the valid pulse
//   stall_if/stall_mem              : per-port stall to the hazard unit
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int TIMEOUT    = 64,
    parameter int MAX_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              err,
    output logic              stall_if,
    output logic              stall_mem
);

    arb_state_e        state_q,     state_d;
    arb_owner_e        owner_q,     owner_d;
    logic              mem_req_q,   mem_req_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_valid_q,  if_valid_d;
    logic              dm_valid_q,  dm_valid_d;
    logic              err_q,       err_d;
    logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q,  dm_rdata_d;
    logic [DATA_W-1:0] resp_data;
    logic              grant_dm;
    logic              fetch_turn;
    logic              wd_clear;
    logic              wd_count;
    logic              wd_expired;

    assign wd_count = (state_q == BUSY);
    assign wd_clear = ~wd_count;

    arb_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (wd_cnt_width(TIMEOUT))
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (wd_clear),
        .count_en (wd_count),
        .expired  (wd_expired)
    );

`ifdef ARB_STARVE_GUARD_EN
    localparam int STREAK_W = $clog2(MAX_STREAK + 1);

    logic [STREAK_W-1:0] streak_q, streak_d;

    // Counts data grants won while fetch was also waiting. Any cycle with
    // fetch idle resets it, so only a continuous fetch wait accumulates.
    always_comb begin
        streak_d = streak_q;
        if (!if_req) begin
            streak_d = '0;
        end else if (state_q == IDLE && (if_req || dm_req)) begin
            streak_d = grant_dm ? (streak_q + STREAK_W'(1)) : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

    assign fetch_turn = (streak_q >= STREAK_W'(MAX_STREAK));
`else
    // Strict data priority; the comparison is constant false but keeps
    // MAX_STREAK referenced in this build.
    assign fetch_turn = (MAX_STREAK < 0);
`endif

    assign grant_dm = dm_req & ~(if_req & fetch_turn);

    // Next-state and registered-output logic. The rdata registers only move
    // on completion, and only for the owning port.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_valid_d  = 1'b0;
        dm_valid_d  = 1'b0;
        err_d       = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        resp_data   = '0;
        case (state_q)
            IDLE: begin
                if (if_req || dm_req) begin
                    state_d   = BUSY;
                    mem_req_d = 1'b1;
                    if (grant_dm) begin
                        owner_d     = OWN_DM;
                        mem_we_d    = dm_we;
                        mem_addr_d  = dm_addr;
                        mem_wdata_d = dm_wdata;
                    end else begin
                        owner_d     = OWN_IF;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                    end
                end
            end
            BUSY: begin
                // An ack in the expiry cycle still counts as a good completion.
                if (mem_ack || wd_expired) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    err_d     = ~mem_ack;
                    if (mem_ack && !mem_we_q) begin
                        resp_data = mem_rdata;
                    end
                    if (owner_q == OWN_DM) begin
                        dm_valid_d = 1'b1;
                        dm_rdata_d = resp_data;
                    end else begin
                        if_valid_d = 1'b1;
                        if_rdata_d = resp_data;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_valid_q  <= 1'b0;
            dm_valid_q  <= 1'b0;
            err_q       <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_valid_q  <= if_valid_d;
            dm_valid_q  <= dm_valid_d;
            err_q       <= err_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_valid  = if_valid_q;
    assign dm_valid  = dm_valid_q;
    assign err       = err_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign stall_if  = if_req & ~if_valid_q;
    assign stall_mem = dm_req & ~dm_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Drives the arbiter from a single initial block, one task per scenario. A
// small memory responder acks after a programmable number of request cycles
// and records what the arbiter presented. Expected values come from the
// transaction-level rules (who wins, latency = delay + 2, stores/timeouts
// return 0) kept in the bench.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int TIMEOUT    = 8;
    localparam int MAX_STREAK = 4;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_valid;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              mem_ack = 1'b0;
    logic              err;
    logic              stall_if;
    logic              stall_mem;

    int checks = 0;
    int errors = 0;

    int          ack_delay = 1;
    bit          ack_en    = 1'b1;
    logic [31:0] resp_data = '0;
    int          busy_cnt  = 0;
    int          req_cycles = 0;
    logic [31:0] cap_addr  = '0;
    logic [31:0] cap_wdata = '0;
    logic        cap_we    = 1'b0;
    bit          unstable  = 1'b0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .TIMEOUT    (TIMEOUT),
        .MAX_STREAK (MAX_STREAK)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_valid  (dm_valid),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .err       (err),
        .stall_if  (stall_if),
        .stall_mem (stall_mem)
    );

    // Memory responder: acks in request cycle number ack_delay (0 = first
    // cycle), records the first-cycle request and whether it ever changed.
    // Read data is garbage except in the ack cycle.
    always @(negedge clk) begin
        if (!mem_req) begin
            busy_cnt = 0;
            mem_ack  = 1'b0;
        end else begin
            if (busy_cnt == 0) begin
                cap_addr  = mem_addr;
                cap_we    = mem_we;
                cap_wdata = mem_wdata;
                unstable  = 1'b0;
            end else if (mem_addr !== cap_addr || mem_we !== cap_we || mem_wdata !== cap_wdata) begin
                unstable = 1'b1;
            end
            mem_ack   = ack_en && (busy_cnt == ack_delay);
            mem_rdata = mem_ack ? resp_data : $urandom;
            busy_cnt++;
            req_cycles = busy_cnt;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_valid(input int limit, output int n, output bit seen);
        seen = 1'b0;
        n    = 0;
        for (int i = 1; i <= limit; i++) begin
            tick();
            if (if_valid || dm_valid) begin
                n    = i;
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0;
        tick();
        tick();
        checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_req got req=%b we=%b expected 0 0", mem_req, mem_we); end
        checks++; if (if_valid !== 1'b0 || dm_valid !== 1'b0 || err !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got if=%b dm=%b err=%b expected 0 0 0", if_valid, dm_valid, err); end
        checks++; if (mem_addr !== '0 || mem_wdata !== '0) begin errors++; $display("[TB] FAIL reset_mem_bus got addr=%h wdata=%h expected 0", mem_addr, mem_wdata); end
        checks++; if (if_rdata !== '0 || dm_rdata !== '0) begin errors++; $display("[TB] FAIL reset_rdata got if=%h dm=%h expected 0", if_rdata, dm_rdata); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_fetch();
        int n; bit seen; bit stall_gap;
        resp_data = 32'h2002000A; ack_delay = 1; ack_en = 1'b1;
        if_addr = 32'h40; if_req = 1'b1;
        seen = 1'b0; n = 0; stall_gap = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (if_valid) begin seen = 1'b1; n = i; break; end
            if (!stall_if) stall_gap = 1'b1;
        end
        checks++; if (!seen || n != 3) begin errors++; $display("[TB] FAIL fetch_latency got seen=%0d cycles=%0d expected 1 3", seen, n); end
        checks++; if (if_rdata !== 32'h2002000A) begin errors++; $display("[TB] FAIL fetch_rdata got %h expected 2002000a", if_rdata); end
        checks++; if (err !== 1'b0 || dm_valid !== 1'b0) begin errors++; $display("[TB] FAIL fetch_err got err=%b dm_valid=%b expected 0 0", err, dm_valid); end
        checks++; if (stall_gap || stall_if !== 1'b0) begin errors++; $display("[TB] FAIL fetch_stall got gap=%0d stall_at_valid=%b expected 0 0", stall_gap, stall_if); end
        checks++; if (cap_addr !== 32'h40 || cap_we !== 1'b0) begin errors++; $display("[TB] FAIL fetch_mem_addr got %h we=%b expected 40 0", cap_addr, cap_we); end
        if_req = 1'b0;
        tick();
        checks++; if (if_valid !== 1'b0) begin errors++; $display("[TB] FAIL fetch_pulse got %b expected 0", if_valid); end
    endtask

    task automatic test_tie();
        int n; bit seen; bit stall_gap;
        ack_delay = 1; resp_data = 32'h11112222;
        if_addr = 32'h40; dm_addr = 32'h100; dm_we = 1'b0; dm_wdata = 32'h0;
        if_req = 1'b1; dm_req = 1'b1;
        stall_gap = 1'b0;
        wait_valid(10, n, seen);
        if (!stall_if) stall_gap = 1'b1;
        checks++; if (!seen || dm_valid !== 1'b1 || n != 3) begin errors++; $display("[TB] FAIL tie_first got seen=%0d dm_valid=%b cycles=%0d expected 1 1 3", seen, dm_valid, n); end
        checks++; if (cap_addr !== 32'h100 || dm_rdata !== 32'h11112222) begin errors++; $display("[TB] FAIL tie_first_data got addr=%h rdata=%h expected 100 11112222", cap_addr, dm_rdata); end
        dm_req = 1'b0; resp_data = 32'h33334444;
        seen = 1'b0; n = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (if_valid || dm_valid) begin seen = 1'b1; n = i; break; end
            if (!stall_if) stall_gap = 1'b1;
        end
        checks++; if (!seen || if_valid !== 1'b1 || n != 4) begin errors++; $display("[TB] FAIL tie_second got seen=%0d if_valid=%b cycles=%0d expected 1 1 4", seen, if_valid, n); end
        checks++; if (cap_addr !== 32'h40 || if_rdata !== 32'h33334444 || dm_rdata !== 32'h11112222) begin errors++; $display("[TB] FAIL tie_second_data got addr=%h if_rdata=%h dm_rdata=%h expected 40 33334444 11112222", cap_addr, if_rdata, dm_rdata); end
        checks++; if (stall_gap) begin errors++; $display("[TB] FAIL tie_stall got gap=%0d expected 0", stall_gap); end
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_store();
        int n; bit seen;
        ack_delay = 5; resp_data = 32'h5A5A5A5A;
        dm_we = 1'b1; dm_addr = 32'h8; dm_wdata = 32'hDEADBEEF; dm_req = 1'b1;
        wait_valid(12, n, seen);
        checks++; if (!seen || dm_valid !== 1'b1 || n != 7) begin errors++; $display("[TB] FAIL store_latency got seen=%0d dm_valid=%b cycles=%0d expected 1 1 7", seen, dm_valid, n); end
        checks++; if (req_cycles != 6 || unstable) begin errors++; $display("[TB] FAIL store_busy got cycles=%0d unstable=%0d expected 6 0", req_cycles, unstable); end
        checks++; if (cap_we !== 1'b1 || cap_wdata !== 32'hDEADBEEF || cap_addr !== 32'h8) begin errors++; $display("[TB] FAIL store_bus got we=%b wdata=%h addr=%h expected 1 deadbeef 8", cap_we, cap_wdata, cap_addr); end
        checks++; if (dm_rdata !== '0 || err !== 1'b0) begin errors++; $display("[TB] FAIL store_rdata got rdata=%h err=%b expected 0 0", dm_rdata, err); end
        dm_req = 1'b0; dm_we = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        int n; bit seen;
        ack_en = 1'b0;
        if_addr = 32'h80; if_req = 1'b1;
        wait_valid(TIMEOUT + 6, n, seen);
        checks++; if (!seen || if_valid !== 1'b1 || n != TIMEOUT + 1) begin errors++; $display("[TB] FAIL timeout_latency got seen=%0d if_valid=%b cycles=%0d expected 1 1 %0d", seen, if_valid, n, TIMEOUT + 1); end
        checks++; if (req_cycles != TIMEOUT || mem_req !== 1'b0) begin errors++; $display("[TB] FAIL timeout_req got cycles=%0d mem_req=%b expected %0d 0", req_cycles, mem_req, TIMEOUT); end
        checks++; if (err !== 1'b1 || if_rdata !== '0) begin errors++; $display("[TB] FAIL timeout_err got err=%b rdata=%h expected 1 0", err, if_rdata); end
        if_req = 1'b0; ack_en = 1'b1;
        tick();
        checks++; if (err !== 1'b0 || if_valid !== 1'b0) begin errors++; $display("[TB] FAIL timeout_clear got err=%b if_valid=%b expected 0 0", err, if_valid); end
    endtask

    task automatic test_reset_mid_busy();
        int n; bit seen;
        ack_delay = 20;
        dm_we = 1'b0; dm_addr = 32'h200; dm_req = 1'b1;
        tick(); tick(); tick();
        checks++; if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL midrst_busy got mem_req=%b expected 1", mem_req); end
        rst_n = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || if_valid !== 1'b0 || dm_valid !== 1'b0 || err !== 1'b0) begin errors++; $display("[TB] FAIL midrst_drop got req=%b ifv=%b dmv=%b err=%b expected 0 0 0 0", mem_req, if_valid, dm_valid, err); end
        dm_req = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        ack_delay = 0; resp_data = 32'hCAFEF00D;
        if_addr = 32'h44; if_req = 1'b1;
        wait_valid(10, n, seen);
        checks++; if (!seen || if_valid !== 1'b1 || n != 2 || if_rdata !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL midrst_fresh got seen=%0d ifv=%b cycles=%0d rdata=%h expected 1 1 2 cafef00d", seen, if_valid, n, if_rdata); end
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_guard();
        int n; bit seen; int streak; bit exp_if; logic [31:0] exp_data;
        streak = 0; ack_delay = 0;
        dm_we = 1'b0; dm_addr = 32'h300; if_addr = 32'h60;
        resp_data = $urandom;
        if_req = 1'b1; dm_req = 1'b1;
        for (int g = 0; g < 10; g++) begin
            exp_data = resp_data;
            if (GUARD && streak >= MAX_STREAK) begin
                exp_if = 1'b1; streak = 0;
            end else begin
                exp_if = 1'b0; streak++;
            end
            wait_valid(10, n, seen);
            checks++;
            if (!seen || if_valid !== exp_if || dm_valid !== !exp_if) begin
                errors++; $display("[TB] FAIL guard_grant%0d got seen=%0d if_valid=%b dm_valid=%b expected if_valid=%b", g, seen, if_valid, dm_valid, exp_if);
            end else if ((exp_if ? if_rdata : dm_rdata) !== exp_data) begin
                errors++; $display("[TB] FAIL guard_rdata%0d got %h expected %h", g, exp_if ? if_rdata : dm_rdata, exp_data);
            end
            resp_data = $urandom;
        end
        if_req = 1'b0; dm_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_random();
        int n; bit seen; bit want_if; bit want_dm; bit own_dm; bit to;
        int dly; logic [31:0] exp_rd; logic [31:0] exp_addr;
        logic [31:0] last_if; logic [31:0] last_dm;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        last_if = '0; last_dm = '0;
        for (int t = 0; t < 40; t++) begin
            want_if = $urandom_range(0, 1);
            want_dm = $urandom_range(0, 1);
            if (!want_if && !want_dm) want_dm = 1'b1;
            if_addr  = $urandom & 32'hFFFF_FFFC;
            dm_addr  = $urandom & 32'hFFFF_FFFC;
            dm_we    = $urandom_range(0, 1);
            dm_wdata = $urandom;
            dly      = $urandom_range(0, 3);
            to       = ($urandom_range(0, 7) == 0);
            ack_delay = dly; ack_en = !to; resp_data = $urandom;
            own_dm   = want_dm;
            exp_rd   = (to || (own_dm && dm_we)) ? 32'h0 : resp_data;
            exp_addr = own_dm ? dm_addr : if_addr;
            if_req = want_if; dm_req = want_dm;
            wait_valid(TIMEOUT + 6, n, seen);
            checks++;
            if (!seen || dm_valid !== own_dm || if_valid !== !own_dm) begin
                errors++; $display("[TB] FAIL rand%0d_owner got seen=%0d ifv=%b dmv=%b expected dm=%b", t, seen, if_valid, dm_valid, own_dm);
            end
            checks++;
            if (n != (to ? TIMEOUT + 1 : dly + 2) || err !== to) begin
                errors++; $display("[TB] FAIL rand%0d_timing got cycles=%0d err=%b expected %0d %b", t, n, err, to ? TIMEOUT + 1 : dly + 2, to);
            end
            if (own_dm) last_dm = exp_rd; else last_if = exp_rd;
            checks++;
            if (if_rdata !== last_if || dm_rdata !== last_dm) begin
                errors++; $display("[TB] FAIL rand%0d_rdata got if=%h dm=%h expected if=%h dm=%h", t, if_rdata, dm_rdata, last_if, last_dm);
            end
            checks++;
            if (cap_addr !== exp_addr || cap_we !== (own_dm & dm_we) || (own_dm && cap_wdata !== dm_wdata)) begin
                errors++; $display("[TB] FAIL rand%0d_membus got addr=%h we=%b wdata=%h expected addr=%h", t, cap_addr, cap_we, cap_wdata, exp_addr);
            end
            if_req = 1'b0; dm_req = 1'b0; ack_en = 1'b1;
            tick();
        end
    endtask

    initial begin
        $display("[TB] starting mem_port_arbiter bench (guard=%0d)", GUARD);
        test_reset();
        test_single_fetch();
        test_tie();
        test_store();
        test_timeout();
        test_reset_mid_busy();
        test_guard();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
